unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's fetch port and its data-memory port. Each requester gets a hold-until-valid handshake and a stall output that freezes the corresponding pipeline stage. Downstream, the memory gets a req/ack handshake with variable latency. The block sits between the five-stage CPU and the memory model, replacing the separate instruction ROM and data RAM.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch read request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_valid; meaningless for writes
- d_valid  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request; held with mem_* stable until mem_ack
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  registered copy of the granted request
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  if_req & ~if_valid
- stall_d  out  1  d_req & ~d_valid

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only one request present: grant it.
  - Both requests present: grant the port not served last (round-robin on the `last` bit).
  - On grant, register mem_we/mem_addr/mem_wdata (mem_we = 0 for fetch), set mem_req = 1, go to BUSY_I or BUSY_D.
  - No request present: stay in IDLE.
- BUSY_x:
  - Hold mem_req and the mem_* fields.
  - On mem_ack: capture mem_rdata into the response register, clear mem_req, update `last` = x, go to RESP.
- RESP:
  - Pulse x_valid with the captured data.
  - Always go to IDLE next.
  - The served requester must drop or replace its request at the following edge.
- Outside the pulse, if_rdata and d_rdata hold their last captured value.
- Ignored inputs:
  - mem_ack in IDLE or RESP is ignored.
  - Changes on an ungranted port's inputs are ignored until it is granted.
- Reset values: state = IDLE, `last` = I (so data wins the first contention), mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, if_valid = 0, d_valid = 0, if_rdata = 0, d_rdata = 0.
- Reset mid-transaction:
  - The outstanding memory access is abandoned and the state returns to IDLE.
  - The memory model must tolerate mem_req dropping without an ack.
  - A late ack is ignored.
- The stall outputs are combinational from the req and valid signals; they are never asserted when the corresponding req is low.

## Timing
- A request is sampled at the edge ending IDLE cycle 0. mem_req is high from cycle 1.
- With mem_ack in cycle k (k ≥ 1), x_valid pulses in cycle k+1 and IDLE is reached in cycle k+2.
- Minimum access is 3 cycles (IDLE, BUSY, RESP). Back-to-back accesses are therefore spaced 3 + (ack latency − 1) cycles.
- A single-cycle-ack memory gives one completion every 3 cycles; under contention the two ports alternate.

## Configuration
- Macro UMA_FAST_RESP_EN.
- Defined:
  - The RESP state is removed.
  - In BUSY_x, x_valid = mem_ack combinationally and x_rdata = mem_rdata passes through in the same cycle.
  - The state goes to IDLE at the ack edge.
  - Minimum access becomes 2 cycles; valid appears in cycle k.
  - The captured-data register still updates, so x_rdata holds the value after the pulse.
- Undefined: the fully registered behaviour described above.

## Structure
- Shared package uma_pkg holds:
  - enum uma_state_e {UmaIdle, UmaBusyI, UmaBusyD, UmaResp}
  - enum uma_port_e {UmaPortI, UmaPortD} for `last`
  - localparam UMA_RESET_LAST = UmaPortI
- One flat module; no sub-module is required. The round-robin pick is a few gates inline.

## Test plan
- **Fetch only:** if_req = 1, if_addr = 0x0000_0040, memory acks 1 cycle after mem_req with 0x2002_0005 -> mem_req in cycle 1, if_valid with if_rdata = 0x2002_0005 in cycle 2 (cycle 1 with UMA_FAST_RESP_EN); stall_if high until the valid cycle.
- **Contention after reset:** if_req and d_req (read, 0x100) raised together -> data is granted first; after its d_valid, fetch is granted; the two ports then alternate while both are held.
- **Data write:** d_we = 1, d_addr = 0x200, d_wdata = 0xDEAD_BEEF, 3-cycle ack latency -> mem_we/mem_addr/mem_wdata stable for all 3 BUSY cycles, d_valid exactly once, no fetch access until RESP has ended.
- **Reset mid-BUSY_D:** reset asserted during the wait, then ack delivered after release -> all outputs return to their reset values immediately (asynchronously), the late ack produces no valid, and the next request is served normally.
- **Stray ack:** mem_ack pulsed while IDLE with no request -> state, valids and rdata unchanged.
- **Held request after valid:** requester keeps if_req high with a new address after if_valid -> a new access is issued to the new address, never a duplicate of the old one.

Source files
------------

// File: rtl/uma_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package uma_pkg;

  typedef enum logic [1:0] {
    UmaIdle,
    UmaBusyI,
    UmaBusyD,
    UmaResp
  } uma_state_e;

  typedef enum logic {
    UmaPortI,
    UmaPortD
  } uma_port_e;

  localparam uma_port_e UMA_RESET_LAST = UmaPortI;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter onto one single-ported memory with req/ack handshake.
// Define UMA_FAST_RESP_EN to drop the RESP state and pass ack/rdata through.
module unified_mem_arbiter
  import uma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);

  uma_state_e        state_q, state_d;
  uma_port_e         last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              sel_data;

  // Data wins when alone, or under contention when fetch was served last.
  assign sel_data = d_req & (~if_req | (last_q == UmaPortI));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      UmaIdle: begin
        if (if_req | d_req) begin
          mem_req_d = 1'b1;
          if (sel_data) begin
            state_d     = UmaBusyD;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = UmaBusyI;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      UmaBusyI: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          last_d     = UmaPortI;
          if_rdata_d = mem_rdata;
`ifdef UMA_FAST_RESP_EN
          state_d    = UmaIdle;
`else
          state_d    = UmaResp;
`endif
        end
      end
      UmaBusyD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          last_d    = UmaPortD;
          d_rdata_d = mem_rdata;
`ifdef UMA_FAST_RESP_EN
          state_d   = UmaIdle;
`else
          state_d   = UmaResp;
`endif
        end
      end
      UmaResp: state_d = UmaIdle;
      default: state_d = UmaIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UmaIdle;
      last_q      <= UMA_RESET_LAST;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef UMA_FAST_RESP_EN
  assign if_valid = (state_q == UmaBusyI) & mem_ack;
  assign d_valid  = (state_q == UmaBusyD) & mem_ack;
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_valid ? mem_rdata : d_rdata_q;
`else
  // In RESP, last_q already names the port just served.
  assign if_valid = (state_q == UmaResp) & (last_q == UmaPortI);
  assign d_valid  = (state_q == UmaResp) & (last_q == UmaPortD);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
`endif

  assign stall_if = if_req & ~if_valid;
  assign stall_d  = d_req & ~d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table plus
// hand-written contention, write, reset and stray-ack sequences.
module tb_unified_mem_arbiter;

`ifdef UMA_FAST_RESP_EN
  localparam int VDLY = 0;
`else
  localparam int VDLY = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_if;
  logic        stall_d;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  exp_t        exp_if_q[$];
  exp_t        exp_d_q[$];
  bit          served[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_n = 0;
  int          dv_n = 0;
  int          lat_r = 1;
  int          lat_w = 1;
  int          mcnt = 0;
  bit          manual = 1'b0;
  logic [31:0] mem_m [logic [31:0]];
  logic        ml_we = 1'b0;
  logic [31:0] ml_addr = '0;
  logic [31:0] ml_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2002_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic exp_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // Memory model: acks after lat cycles of mem_req, logs the access.
  initial begin
    mem_m[32'h40] = 32'h2002_0005;
    forever begin
      @(posedge clk); #1;
      if (!manual) begin
        mem_ack = 1'b0;
        if (mem_req && !reset) begin
          mcnt++;
          if (mcnt >= (mem_we ? lat_w : lat_r)) begin
            mcnt = 0;
            mem_ack = 1'b1;
            acc_n++;
            ml_we = mem_we; ml_addr = mem_addr; ml_wdata = mem_wdata;
            if (mem_we) begin
              mem_m[mem_addr] = mem_wdata;
              mem_rdata = 32'hFFFF_FFFF;
            end else begin
              mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr]
                                                 : (mem_addr ^ 32'hA5A5_0000);
            end
          end
        end else mcnt = 0;
      end else mcnt = 0;
    end
  end

  task automatic done_chk(input string p, input exp_t e,
                          input logic [31:0] rd);
    chk({p, "_mem_addr"}, ml_addr, e.addr);
    chk({p, "_mem_we"}, {31'b0, ml_we}, {31'b0, e.we});
    if (e.we) chk({p, "_mem_wdata"}, ml_wdata, e.wdata);
    else chk({p, "_rdata"}, rd, e.rdata);
  endtask

  // Scoreboard: each completion pops that port's expected record.
  always @(negedge clk) begin
    exp_t em;
    if (if_valid) begin
      served.push_back(1'b0);
      if (exp_if_q.size() == 0) bad("if_valid_unexpected");
      else begin
        em = exp_if_q.pop_front();
        done_chk("if", em, if_rdata);
      end
    end
    if (d_valid) begin
      dv_n++;
      served.push_back(1'b1);
      if (exp_d_q.size() == 0) bad("d_valid_unexpected");
      else begin
        em = exp_d_q.pop_front();
        done_chk("d", em, d_rdata);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_if_q.delete();
    exp_d_q.delete();
  endtask

  task automatic do_txn(input vec_t v);
    int   c0;
    bit   got;
    logic vv, st;
    got = 1'b0;
    lat_r = v.lat;
    lat_w = v.lat;
    if (v.port) exp_d_q.push_back(mk(v.we, v.addr, v.wdata, v.rdata));
    else exp_if_q.push_back(mk(v.we, v.addr, v.wdata, v.rdata));
    @(posedge clk); #1;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    c0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      vv = v.port ? d_valid : if_valid;
      st = v.port ? stall_d : stall_if;
      if (vv) begin
        got = 1'b1;
        chk("valid_cycle", cyc - c0, v.lat + VDLY);
        chk("stall_at_valid", {31'b0, st}, 32'd0);
      end else chk("stall_wait", {31'b0, st}, 32'd1);
    end
    if (!got) bad("txn_timeout");
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    vec_t        tbl[6];
    logic [31:0] ia, da;
    int          nd, vd, vi, nbusy, dv0, a0, nv;
    bit          fi, fd, dd, di;

    tbl[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         1, 32'h2002_0005};
    tbl[1] = '{1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 3, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h200, 32'h0,         2, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b0, 32'h44,  32'h0,         1, 32'hA5A5_0044};
    tbl[4] = '{1'b1, 1'b0, 32'h100, 32'h0,         4, 32'hA5A5_0100};
    tbl[5] = '{1'b0, 1'b0, 32'h200, 32'h0,         1, 32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall_if", {31'b0, stall_if}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[k]) do_txn(tbl[k]);

    // Contention from reset: data first, then strict alternation.
    apply_reset();
    lat_r = 1; lat_w = 1;
    served.delete();
    ia = 32'h80; da = 32'h100; nd = 0;
    exp_if_q.push_back(mk(1'b0, ia, 32'h0, ref_rd(ia)));
    exp_d_q.push_back(mk(1'b0, da, 32'h0, ref_rd(da)));
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = ia;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int i = 0; i < 60 && nd < 4; i++) begin
      @(negedge clk);
      fi = if_valid; fd = d_valid;
      if (fi || fd) nd++;
      @(posedge clk); #1;
      if (nd < 4) begin
        if (fi) begin
          ia += 32'h4;
          exp_if_q.push_back(mk(1'b0, ia, 32'h0, ref_rd(ia)));
          if_addr = ia;
        end
        if (fd) begin
          da += 32'h4;
          exp_d_q.push_back(mk(1'b0, da, 32'h0, ref_rd(da)));
          d_addr = da;
        end
      end
    end
    if (nd < 4) bad("contention_timeout");
    if_req = 1'b0; d_req = 1'b0;
    exp_if_q.delete(); exp_d_q.delete();
    chk("rr_count", served.size(), 32'd4);
    for (int k = 0; k < 4 && k < served.size(); k++)
      chk("rr_order", {31'b0, served[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);

    // Slow write with a competing fetch held off until RESP ends.
    apply_reset();
    lat_w = 3; lat_r = 1; dv0 = dv_n;
    dd = 1'b0; di = 1'b0; nbusy = 0; vd = 0; vi = 0;
    exp_d_q.push_back(mk(1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0));
    exp_if_q.push_back(mk(1'b0, 32'h48, 32'h0, ref_rd(32'h48)));
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h48;
    for (int i = 0; i < 60 && !(dd && di); i++) begin
      @(negedge clk);
      if (mem_req && !dd) begin
        nbusy++;
        chk("wr_mem_addr", mem_addr, 32'h200);
        chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (d_valid) begin dd = 1'b1; vd = cyc; end
      if (if_valid) begin di = 1'b1; vi = cyc; end
      @(posedge clk); #1;
      if (dd) begin d_req = 1'b0; d_we = 1'b0; end
      if (di) if_req = 1'b0;
    end
    if (!(dd && di)) bad("wr_timeout");
    chk("wr_busy_cycles", nbusy, 32'd3);
    chk("wr_fetch_gap", vi - vd, 2 + VDLY);
    chk("wr_d_valid_once", dv_n - dv0, 32'd1);

    // Reset during BUSY_D; the late ack must be ignored.
    apply_reset();
    manual = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_mem_req", {31'b0, mem_req}, 32'd1);
    chk("mid_mem_addr", mem_addr, 32'h300);
    chk("mid_stall_d", {31'b0, stall_d}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("arst_d_valid", {31'b0, d_valid}, 32'd0);
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_d_valid", {31'b0, d_valid}, 32'd0);
    chk("late_d_rdata", d_rdata, 32'd0);
    chk("late_stall_d", {31'b0, stall_d}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_d_valid2", {31'b0, d_valid}, 32'd0);
    chk("late_mem_req", {31'b0, mem_req}, 32'd0);

    // Stray ack while idle.
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_if_valid", {31'b0, if_valid}, 32'd0);
    chk("stray_d_valid", {31'b0, d_valid}, 32'd0);
    chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_if_rdata", if_rdata, 32'd0);
    chk("stray_d_rdata", d_rdata, 32'd0);
    chk("stray_d_valid2", {31'b0, d_valid}, 32'd0);
    manual = 1'b0;
    do_txn('{1'b1, 1'b0, 32'h300, 32'h0, 2, 32'hA5A5_0300});

    // Held fetch request retargeted right after its valid.
    a0 = acc_n; lat_r = 1; nv = 0;
    exp_if_q.push_back(mk(1'b0, 32'h50, 32'h0, ref_rd(32'h50)));
    exp_if_q.push_back(mk(1'b0, 32'h54, 32'h0, ref_rd(32'h54)));
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h50;
    for (int i = 0; i < 40 && nv < 2; i++) begin
      @(negedge clk);
      fi = if_valid;
      if (fi) nv++;
      @(posedge clk); #1;
      if (fi && nv == 1) if_addr = 32'h54;
      if (nv == 2) if_req = 1'b0;
    end
    if (nv < 2) bad("held_timeout");
    if_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_acc_n", acc_n - a0, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
